// File: rtl/rw_pkg.sv
// Shared widths, solver slot tags and the retry-entry payload for the
// read/write conflict solver and its retire stage.
package rw_pkg;

    localparam int unsigned DATA1_LEN  = 12;
    localparam int unsigned DATA2_LEN  = 12;
    localparam int unsigned OTHER_INFO = 30;
    localparam int unsigned LOC_WIDTH  = 6;
    localparam int unsigned STAT_W     = 32;

    typedef enum logic [1:0] {
        UNVALID = 2'b00,
        READY   = 2'b01,
        VALID   = 2'b11
    } slot_tag_e;

    typedef struct packed {
        logic [DATA1_LEN-1:0]  data1;
        logic [DATA2_LEN-1:0]  data2;
        logic [OTHER_INFO-1:0] other_info;
    } retry_entry_t;

endpackage

// File: rtl/rw_retire_ctrl_if.sv
// Solver-result, commit, delete and retry handshake bundle of rw_retire_ctrl.
// slave = retire stage view, master = solver/arbiter side view.
interface rw_retire_ctrl_if
    import rw_pkg::*;
#(
    parameter int unsigned RETRY_AW = 4
);
    logic                  in_valid;
    logic [DATA1_LEN-1:0]  in_data1;
    logic [DATA2_LEN-1:0]  in_data2;
    logic [OTHER_INFO-1:0] in_other_info;
    logic                  in_insert_success;
    logic [LOC_WIDTH-1:0]  in_insert_loc;

    logic                  valid_delete;
    logic [LOC_WIDTH-1:0]  del_loc;

    logic                  commit_valid;
    logic [LOC_WIDTH-1:0]  commit_loc;
    logic [OTHER_INFO-1:0] commit_other_info;

    logic                  retry_valid;
    logic                  retry_ready;
    logic [DATA1_LEN-1:0]  retry_data1;
    logic [DATA2_LEN-1:0]  retry_data2;
    logic [OTHER_INFO-1:0] retry_other_info;
    logic                  drop_valid;
    logic [RETRY_AW:0]     retry_count;

    modport slave (
        input  in_valid, in_data1, in_data2, in_other_info,
               in_insert_success, in_insert_loc, retry_ready,
        output valid_delete, del_loc, commit_valid, commit_loc,
               commit_other_info, retry_valid, retry_data1, retry_data2,
               retry_other_info, drop_valid, retry_count
    );

    modport master (
        output in_valid, in_data1, in_data2, in_other_info,
               in_insert_success, in_insert_loc, retry_ready,
        input  valid_delete, del_loc, commit_valid, commit_loc,
               commit_other_info, retry_valid, retry_data1, retry_data2,
               retry_other_info, drop_valid, retry_count
    );

endinterface

// File: rtl/rw_retry_fifo.sv
// Show-ahead synchronous FIFO for failed inserts; the caller only issues
// legal push/pop (push on full requires a simultaneous pop).
module rw_retry_fifo
    import rw_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  retry_entry_t wdata,
    output retry_entry_t rdata,
    output logic [AW:0]  count,
    output logic         full,
    output logic         empty
);

    retry_entry_t      mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       cnt;

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is not reset; head data is masked while empty
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign count = cnt;
    assign empty = (cnt == '0);
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/rw_retire_ctrl.sv
// Retire stage behind the 1-clock r/w conflict solver: commits successes,
// returns slots after RETIRE_LAT cycles, queues failures for retry.
// Optional statistics counters: define RW_RETIRE_STATS_EN.
module rw_retire_ctrl
    import rw_pkg::*;
#(
    parameter int unsigned RETIRE_LAT  = 8,
    parameter int unsigned RETRY_DEPTH = 16,
    parameter int unsigned RETRY_AW    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    rw_retire_ctrl_if.slave      bus
`ifdef RW_RETIRE_STATS_EN
    ,
    output logic [STAT_W-1:0]    stat_commits,
    output logic [STAT_W-1:0]    stat_retries,
    output logic [STAT_W-1:0]    stat_drops
`endif
);

    logic                  success;
    logic                  failure;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [RETRY_AW:0]     fifo_count;
    retry_entry_t          wentry;
    retry_entry_t          head;

    logic                  commit_valid_q;
    logic [LOC_WIDTH-1:0]  commit_loc_q;
    logic [OTHER_INFO-1:0] commit_info_q;
    logic                  drop_q;

    logic [RETIRE_LAT-1:0] pipe_v;
    logic [LOC_WIDTH-1:0]  pipe_loc [RETIRE_LAT];

    assign success = bus.in_valid &  bus.in_insert_success;
    assign failure = bus.in_valid & ~bus.in_insert_success;
    assign pop     = ~fifo_empty & bus.retry_ready;
    assign push    = failure & (~fifo_full | pop);
    assign drop    = failure &  fifo_full & ~pop;

    assign wentry.data1      = bus.in_data1;
    assign wentry.data2      = bus.in_data2;
    assign wentry.other_info = bus.in_other_info;

    rw_retry_fifo #(
        .DEPTH (RETRY_DEPTH),
        .AW    (RETRY_AW)
    ) u_retry_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wentry),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Commit report and drop pulse, one cycle after the solver result
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_valid_q <= 1'b0;
            commit_loc_q   <= '0;
            commit_info_q  <= '0;
            drop_q         <= 1'b0;
        end else begin
            commit_valid_q <= success;
            commit_loc_q   <= success ? bus.in_insert_loc : '0;
            commit_info_q  <= success ? bus.in_other_info : '0;
            drop_q         <= drop;
        end
    end

    // Retire pipeline head: loc is zeroed for bubbles so del_loc idles at 0
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v[0]   <= 1'b0;
            pipe_loc[0] <= '0;
        end else begin
            pipe_v[0]   <= success;
            pipe_loc[0] <= success ? bus.in_insert_loc : '0;
        end
    end

    for (genvar g = 1; g < int'(RETIRE_LAT); g++) begin : g_pipe
        always_ff @(posedge clk) begin
            if (rst) begin
                pipe_v[g]   <= 1'b0;
                pipe_loc[g] <= '0;
            end else begin
                pipe_v[g]   <= pipe_v[g-1];
                pipe_loc[g] <= pipe_loc[g-1];
            end
        end
    end

    assign bus.valid_delete      = pipe_v[RETIRE_LAT-1];
    assign bus.del_loc           = pipe_loc[RETIRE_LAT-1];
    assign bus.commit_valid      = commit_valid_q;
    assign bus.commit_loc        = commit_loc_q;
    assign bus.commit_other_info = commit_info_q;
    assign bus.drop_valid        = drop_q;
    assign bus.retry_valid       = ~fifo_empty;
    assign bus.retry_count       = fifo_count;
    assign bus.retry_data1       = head.data1;
    assign bus.retry_data2       = head.data2;
    assign bus.retry_other_info  = head.other_info;

`ifdef RW_RETIRE_STATS_EN
    // Saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_commits <= '0;
            stat_retries <= '0;
            stat_drops   <= '0;
        end else begin
            if (success && (stat_commits != '1)) stat_commits <= stat_commits + STAT_W'(1);
            if (push    && (stat_retries != '1)) stat_retries <= stat_retries + STAT_W'(1);
            if (drop    && (stat_drops   != '1)) stat_drops   <= stat_drops   + STAT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_rw_retire_ctrl.sv
// Self-checking bench for rw_retire_ctrl: directed scenarios plus random
// traffic against a queue/schedule reference model.
module tb_rw_retire_ctrl;
    import rw_pkg::*;

    localparam int LAT      = 8;
    localparam int DEPTH    = 16;
    localparam int RETRY_AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rw_retire_ctrl_if #(.RETRY_AW(RETRY_AW)) bus ();

`ifdef RW_RETIRE_STATS_EN
    logic [31:0] stat_commits;
    logic [31:0] stat_retries;
    logic [31:0] stat_drops;
`endif

    rw_retire_ctrl #(
        .RETIRE_LAT  (LAT),
        .RETRY_DEPTH (DEPTH),
        .RETRY_AW    (RETRY_AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus)
`ifdef RW_RETIRE_STATS_EN
        ,
        .stat_commits (stat_commits),
        .stat_retries (stat_retries),
        .stat_drops   (stat_drops)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    int                   cyc = 0;
    retry_entry_t         mq[$];
    logic [LOC_WIDTH-1:0] del_at [int];
    logic                 e_cv;
    logic [LOC_WIDTH-1:0] e_cl;
    logic [OTHER_INFO-1:0] e_co;
    logic                 e_drop;
    logic                 e_vd;
    logic [LOC_WIDTH-1:0] e_dl;
    int                   m_commits, m_retries, m_drops;

    task automatic drive(input logic v, input logic s, input logic [LOC_WIDTH-1:0] loc,
                         input logic [DATA1_LEN-1:0] d1, input logic [DATA2_LEN-1:0] d2,
                         input logic [OTHER_INFO-1:0] oi);
        bus.in_valid          = v;
        bus.in_insert_success = s;
        bus.in_insert_loc     = loc;
        bus.in_data1          = d1;
        bus.in_data2          = d2;
        bus.in_other_info     = oi;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, '0, '0);
    endtask

    // One clock edge; the model applies the rules to the inputs held across it
    task automatic tick();
        logic succ, fl, pp, ps, dr, r;
        logic [LOC_WIDTH-1:0]  loc;
        logic [OTHER_INFO-1:0] oi;
        retry_entry_t ent;
        int t;
        r    = rst;
        succ = bus.in_valid && bus.in_insert_success;
        fl   = bus.in_valid && !bus.in_insert_success;
        pp   = (mq.size() > 0) && bus.retry_ready;
        ps   = fl && ((mq.size() < DEPTH) || pp);
        dr   = fl && !ps;
        loc  = bus.in_insert_loc;
        oi   = bus.in_other_info;
        ent.data1      = bus.in_data1;
        ent.data2      = bus.in_data2;
        ent.other_info = bus.in_other_info;
        @(posedge clk);
        #1;
        t   = cyc;
        cyc = cyc + 1;
        if (r) begin
            mq.delete();
            del_at.delete();
            e_cv = 1'b0; e_cl = '0; e_co = '0; e_drop = 1'b0;
            m_commits = 0; m_retries = 0; m_drops = 0;
        end else begin
            if (pp) void'(mq.pop_front());
            if (ps) mq.push_back(ent);
            if (succ) del_at[t + LAT] = loc;
            e_cv   = succ;
            e_cl   = succ ? loc : '0;
            e_co   = succ ? oi : '0;
            e_drop = dr;
            if (succ) m_commits++;
            if (ps)   m_retries++;
            if (dr)   m_drops++;
        end
        e_vd = del_at.exists(cyc);
        e_dl = e_vd ? del_at[cyc] : '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.retry_ready = 1'b0;
        tick();
        tick();
        total++;
        if (bus.commit_valid !== 1'b0 || bus.commit_loc !== '0 || bus.commit_other_info !== '0) begin
            bad++; $display("FAIL reset_commit got v=%0b loc=%0d oi=%0h want 0", bus.commit_valid, bus.commit_loc, bus.commit_other_info);
        end
        total++;
        if (bus.valid_delete !== 1'b0 || bus.del_loc !== '0) begin
            bad++; $display("FAIL reset_delete got v=%0b loc=%0d want 0", bus.valid_delete, bus.del_loc);
        end
        total++;
        if (bus.retry_valid !== 1'b0 || bus.retry_count !== '0 || bus.drop_valid !== 1'b0) begin
            bad++; $display("FAIL reset_retry got v=%0b cnt=%0d drop=%0b want 0", bus.retry_valid, bus.retry_count, bus.drop_valid);
        end
`ifdef RW_RETIRE_STATS_EN
        total++;
        if (stat_commits !== 0 || stat_retries !== 0 || stat_drops !== 0) begin
            bad++; $display("FAIL reset_stats got %0d %0d %0d want 0", stat_commits, stat_retries, stat_drops);
        end
`endif
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            total++;
            if (bus.valid_delete !== 1'b0) begin
                bad++; $display("FAIL idle_delete cycle %0d got %0b want 0", k, bus.valid_delete);
            end
        end
    endtask

    task automatic test_single_success();
        drive(1'b1, 1'b1, 6'd9, 12'h5a, 12'ha5, 30'h1234);
        tick();
        total++;
        if (bus.commit_valid !== 1'b1 || bus.commit_loc !== 6'd9 || bus.commit_other_info !== 30'h1234) begin
            bad++; $display("FAIL single_commit got v=%0b loc=%0d oi=%0h want 1/9/1234", bus.commit_valid, bus.commit_loc, bus.commit_other_info);
        end
        idle();
        for (int k = 1; k <= LAT + 3; k++) begin
            total++;
            if (bus.valid_delete !== (k == LAT) || bus.del_loc !== ((k == LAT) ? 6'd9 : 6'd0)) begin
                bad++; $display("FAIL single_delete k=%0d got v=%0b loc=%0d want v=%0b", k, bus.valid_delete, bus.del_loc, (k == LAT));
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [LOC_WIDTH-1:0] want;
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, 1'b1, 6'(3 + j), '0, '0, 30'(j + 100));
            tick();
            total++;
            if (bus.commit_valid !== 1'b1 || bus.commit_loc !== 6'(3 + j)) begin
                bad++; $display("FAIL b2b_commit j=%0d got v=%0b loc=%0d want 1/%0d", j, bus.commit_valid, bus.commit_loc, 3 + j);
            end
        end
        idle();
        for (int k = 3; k <= LAT + 5; k++) begin
            want = (k >= LAT && k <= LAT + 2) ? 6'(3 + k - LAT) : 6'd0;
            total++;
            if (bus.valid_delete !== (k >= LAT && k <= LAT + 2) || bus.del_loc !== want) begin
                bad++; $display("FAIL b2b_delete k=%0d got v=%0b loc=%0d want loc=%0d", k, bus.valid_delete, bus.del_loc, want);
            end
            tick();
        end
    endtask

    task automatic test_retry_order();
        bus.retry_ready = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            drive(1'b1, 1'b0, '0, 12'(j), 12'($urandom), 30'($urandom));
            tick();
        end
        idle();
        for (int k = 0; k < 3; k++) begin
            total++;
            if (bus.retry_valid !== 1'b1 || bus.retry_count !== 5'd3 || bus.retry_data1 !== 12'd1) begin
                bad++; $display("FAIL retry_hold k=%0d got v=%0b cnt=%0d d1=%0d want 1/3/1", k, bus.retry_valid, bus.retry_count, bus.retry_data1);
            end
            tick();
        end
        bus.retry_ready = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            total++;
            if (bus.retry_valid !== 1'b1 || bus.retry_data1 !== 12'(j) || bus.retry_data2 !== mq[0].data2) begin
                bad++; $display("FAIL retry_pop j=%0d got v=%0b d1=%0d want 1/%0d", j, bus.retry_valid, bus.retry_data1, j);
            end
            tick();
        end
        total++;
        if (bus.retry_valid !== 1'b0 || bus.retry_count !== 5'd0) begin
            bad++; $display("FAIL retry_empty got v=%0b cnt=%0d want 0/0", bus.retry_valid, bus.retry_count);
        end
        bus.retry_ready = 1'b0;
    endtask

    task automatic test_full();
        int n;
        bus.retry_ready = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            drive(1'b1, 1'b0, '0, 12'(16 + j), 12'(j), 30'(j));
            tick();
            total++;
            if (bus.drop_valid !== 1'b0) begin
                bad++; $display("FAIL fill_drop j=%0d got %0b want 0", j, bus.drop_valid);
            end
        end
        total++;
        if (bus.retry_count !== 5'd16) begin
            bad++; $display("FAIL fill_count got %0d want 16", bus.retry_count);
        end
        drive(1'b1, 1'b0, '0, 12'd99, '0, '0);
        tick();
        total++;
        if (bus.drop_valid !== 1'b1 || bus.retry_count !== 5'd16) begin
            bad++; $display("FAIL full_drop got drop=%0b cnt=%0d want 1/16", bus.drop_valid, bus.retry_count);
        end
        idle();
        tick();
        total++;
        if (bus.drop_valid !== 1'b0) begin
            bad++; $display("FAIL drop_pulse got %0b want 0", bus.drop_valid);
        end
        drive(1'b1, 1'b0, '0, 12'd100, '0, '0);
        bus.retry_ready = 1'b1;
        tick();
        total++;
        if (bus.drop_valid !== 1'b0 || bus.retry_count !== 5'd16 || bus.retry_data1 !== 12'd17) begin
            bad++; $display("FAIL full_pushpop got drop=%0b cnt=%0d d1=%0d want 0/16/17", bus.drop_valid, bus.retry_count, bus.retry_data1);
        end
        idle();
        n = 0;
        while (bus.retry_valid === 1'b1 && n < 40) begin
            total++;
            if (bus.retry_data1 !== mq[0].data1) begin
                bad++; $display("FAIL drain_head got %0d want %0d", bus.retry_data1, mq[0].data1);
            end
            tick();
            n++;
        end
        total++;
        if (bus.retry_valid !== 1'b0 || n != 16) begin
            bad++; $display("FAIL drain_len got pops=%0d v=%0b want 16/0", n, bus.retry_valid);
        end
        bus.retry_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 6'($urandom),
                  12'($urandom), 12'($urandom), 30'($urandom));
            bus.retry_ready = (k % 100 < 50) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 1);
            tick();
            total++;
            if (bus.commit_valid !== e_cv || bus.commit_loc !== e_cl || bus.commit_other_info !== e_co) begin
                bad++; $display("FAIL rnd_commit k=%0d got %0b/%0d/%0h want %0b/%0d/%0h", k, bus.commit_valid, bus.commit_loc, bus.commit_other_info, e_cv, e_cl, e_co);
            end
            total++;
            if (bus.valid_delete !== e_vd || bus.del_loc !== e_dl) begin
                bad++; $display("FAIL rnd_delete k=%0d got %0b/%0d want %0b/%0d", k, bus.valid_delete, bus.del_loc, e_vd, e_dl);
            end
            total++;
            if (bus.drop_valid !== e_drop || bus.retry_count !== 5'(mq.size()) || bus.retry_valid !== (mq.size() != 0)) begin
                bad++; $display("FAIL rnd_fifo k=%0d got drop=%0b cnt=%0d v=%0b want %0b/%0d", k, bus.drop_valid, bus.retry_count, bus.retry_valid, e_drop, mq.size());
            end
            if (mq.size() > 0) begin
                total++;
                if (bus.retry_data1 !== mq[0].data1 || bus.retry_data2 !== mq[0].data2 || bus.retry_other_info !== mq[0].other_info) begin
                    bad++; $display("FAIL rnd_head k=%0d got %0h/%0h/%0h want %0h/%0h/%0h", k, bus.retry_data1, bus.retry_data2, bus.retry_other_info, mq[0].data1, mq[0].data2, mq[0].other_info);
                end
            end
        end
`ifdef RW_RETIRE_STATS_EN
        total++;
        if (stat_commits !== 32'(m_commits) || stat_retries !== 32'(m_retries) || stat_drops !== 32'(m_drops)) begin
            bad++; $display("FAIL rnd_stats got %0d/%0d/%0d want %0d/%0d/%0d", stat_commits, stat_retries, stat_drops, m_commits, m_retries, m_drops);
        end
`endif
        idle();
        bus.retry_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        int n;
        bus.retry_ready = 1'b1;
        idle();
        n = 0;
        while ((bus.retry_valid === 1'b1 || n < LAT + 2) && n < 60) begin
            tick();
            n++;
        end
        bus.retry_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            drive(1'b1, 1'b0, '0, 12'(j + 1), '0, '0);
            tick();
        end
        drive(1'b1, 1'b1, 6'd20, '0, '0, 30'h77);
        tick();
        drive(1'b1, 1'b1, 6'd21, '0, '0, 30'h78);
        tick();
        total++;
        if (bus.retry_count !== 5'd4) begin
            bad++; $display("FAIL pre_reset_count got %0d want 4", bus.retry_count);
        end
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (bus.retry_valid !== 1'b0 || bus.retry_count !== 5'd0 || bus.commit_valid !== 1'b0) begin
            bad++; $display("FAIL mid_reset got v=%0b cnt=%0d cv=%0b want 0", bus.retry_valid, bus.retry_count, bus.commit_valid);
        end
`ifdef RW_RETIRE_STATS_EN
        total++;
        if (stat_commits !== 0 || stat_retries !== 0 || stat_drops !== 0) begin
            bad++; $display("FAIL mid_reset_stats got %0d/%0d/%0d want 0", stat_commits, stat_retries, stat_drops);
        end
`endif
        for (int k = 0; k < LAT + 4; k++) begin
            tick();
            total++;
            if (bus.valid_delete !== 1'b0 || bus.del_loc !== 6'd0) begin
                bad++; $display("FAIL post_reset_delete k=%0d got %0b/%0d want 0", k, bus.valid_delete, bus.del_loc);
            end
        end
    endtask

    initial begin
        idle();
        bus.retry_ready = 1'b0;
        test_reset();
        test_single_success();
        test_back_to_back();
        test_retry_order();
        test_full();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
